vend_controller: RTL and testbench

VEND_CONTROLLER -- requirements
Module: vend_controller

---
 rtl/vend_pkg.sv | 42 ++++
 rtl/vend_controller_if.sv | 38 +++
 rtl/change_picker.sv | 26 ++
 rtl/vend_controller.sv | 129 ++++++++++++
 tb/tb_vend_controller.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending checkout controller.
// Coin one-hot codes match the money-input stage's type codes.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_VEND   = 3'd2,
        S_CHANGE = 3'd3,
        S_DONE   = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    localparam int unsigned DEN_500  = 500;
    localparam int unsigned DEN_1000 = 1000;
    localparam int unsigned DEN_2000 = 2000;
    localparam int unsigned DEN_5000 = 5000;

    localparam logic [3:0] COIN_NONE = 4'b0000;
    localparam logic [3:0] COIN_500  = 4'b0001;
    localparam logic [3:0] COIN_1000 = 4'b0010;
    localparam logic [3:0] COIN_2000 = 4'b0100;
    localparam logic [3:0] COIN_5000 = 4'b1000;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_CREDIT = 2'b01;
    localparam logic [1:0] ERR_SHORT  = 2'b10;

    function automatic int unsigned coin_value(input logic [3:0] coin);
        int unsigned v;
        v = 0;
        case (coin)
            COIN_500:  v = DEN_500;
            COIN_1000: v = DEN_1000;
            COIN_2000: v = DEN_2000;
            COIN_5000: v = DEN_5000;
            default:   v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Bundle between the checkout controller and its neighbour stages.
// master drives requests and stock; slave is the controller.
interface vend_controller_if #(
    parameter int VAL_W = 16,
    parameter int CNT_W = 8
);
    logic [VAL_W-1:0] credit;
    logic [VAL_W-1:0] price;
    logic [2:0]       sel;
    logic             buy;
    logic             cancel;
    logic [CNT_W-1:0] stock_500;
    logic [CNT_W-1:0] stock_1000;
    logic [CNT_W-1:0] stock_2000;
    logic [CNT_W-1:0] stock_5000;
    logic             busy;
    logic             vend;
    logic [2:0]       vend_addr;
    logic [3:0]       coin_out;
    logic             credit_clr;
    logic [1:0]       err;
    logic [VAL_W-1:0] change_owed;

    modport master (
        output credit, price, sel, buy, cancel,
        output stock_500, stock_1000, stock_2000, stock_5000,
        input  busy, vend, vend_addr, coin_out,
        input  credit_clr, err, change_owed
    );

    modport slave (
        input  credit, price, sel, buy, cancel,
        input  stock_500, stock_1000, stock_2000, stock_5000,
        output busy, vend, vend_addr, coin_out,
        output credit_clr, err, change_owed
    );

endinterface

// File: rtl/change_picker.sv
// Picks the largest in-stock denomination not exceeding the remainder.
// Returns a one-hot coin code, or zero when nothing fits.
module change_picker
    import vend_pkg::*;
#(
    parameter int VAL_W = 16,
    parameter int CNT_W = 8
) (
    input  logic [VAL_W-1:0]      remainder,
    input  logic [3:0][CNT_W-1:0] cnt,
    output logic [3:0]            pick
);

    always_comb begin
        pick = COIN_NONE;
        if (remainder >= VAL_W'(DEN_5000) && cnt[3] != '0)
            pick = COIN_5000;
        else if (remainder >= VAL_W'(DEN_2000) && cnt[2] != '0)
            pick = COIN_2000;
        else if (remainder >= VAL_W'(DEN_1000) && cnt[1] != '0)
            pick = COIN_1000;
        else if (remainder >= VAL_W'(DEN_500) && cnt[0] != '0)
            pick = COIN_500;
    end

endmodule

// File: rtl/vend_controller.sv
// Checkout controller: checks credit, vends, pays change coin by coin.
// Pulses are registered; stock is snapshotted when a request is accepted.
module vend_controller
    import vend_pkg::*;
#(
    parameter int VAL_W = 16,
    parameter int CNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    vend_controller_if.slave bus
);

    state_t state, state_n;

    logic [VAL_W-1:0]      rem, rem_n;
    logic [VAL_W-1:0]      prc, prc_n;
    logic [VAL_W-1:0]      owed, owed_n;
    logic [2:0]            addr, addr_n;
    logic [3:0][CNT_W-1:0] cnt, cnt_n, stock;
    logic [1:0]            err, err_n;
    logic [3:0]            pick, coin, coin_n;
    logic                  vend, clr;

    assign stock = {bus.stock_5000, bus.stock_2000,
                    bus.stock_1000, bus.stock_500};

    change_picker #(
        .VAL_W (VAL_W),
        .CNT_W (CNT_W)
    ) u_pick (
        .remainder (rem),
        .cnt       (cnt),
        .pick      (pick)
    );

    always_comb begin
        state_n = state;
        rem_n   = rem;
        prc_n   = prc;
        owed_n  = owed;
        addr_n  = addr;
        cnt_n   = cnt;
        err_n   = err;
        coin_n  = COIN_NONE;
        unique case (state)
            S_IDLE: begin
                // cancel takes priority over a simultaneous buy
                if (bus.cancel) begin
                    state_n = S_CHANGE;
                    rem_n   = bus.credit;
                    cnt_n   = stock;
                    err_n   = ERR_NONE;
                    owed_n  = '0;
                end else if (bus.buy) begin
                    state_n = S_CHECK;
                    rem_n   = bus.credit;
                    prc_n   = bus.price;
                    addr_n  = bus.sel;
                    cnt_n   = stock;
                    err_n   = ERR_NONE;
                    owed_n  = '0;
                end
            end
            S_CHECK: begin
                if (rem < prc) begin
                    state_n = S_FAIL;
                    err_n   = ERR_CREDIT;
                end else begin
                    state_n = S_VEND;
                    rem_n   = rem - prc;
                end
            end
            S_FAIL: state_n = S_IDLE;
            S_VEND: state_n = S_CHANGE;
            S_CHANGE: begin
                if (rem == '0) begin
                    state_n = S_DONE;
                end else if (pick != COIN_NONE) begin
                    coin_n = pick;
                    rem_n  = rem - VAL_W'(coin_value(pick));
                    for (int i = 0; i < 4; i++)
                        if (pick[i]) cnt_n[i] = cnt[i] - CNT_W'(1);
                end else begin
                    state_n = S_DONE;
                    err_n   = ERR_SHORT;
                    owed_n  = rem;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
            rem   <= '0;
            prc   <= '0;
            owed  <= '0;
            addr  <= '0;
            cnt   <= '0;
            err   <= ERR_NONE;
            coin  <= COIN_NONE;
            vend  <= 1'b0;
            clr   <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            prc   <= prc_n;
            owed  <= owed_n;
            addr  <= addr_n;
            cnt   <= cnt_n;
            err   <= err_n;
            coin  <= coin_n;
            vend  <= (state_n == S_VEND);
            clr   <= (state_n == S_DONE);
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.vend        = vend;
    assign bus.vend_addr   = addr;
    assign bus.coin_out    = coin;
    assign bus.credit_clr  = clr;
    assign bus.err         = err;
    assign bus.change_owed = owed;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus random purchases,
// compared cycle by cycle against a greedy-change reference model.
module tb_vend_controller;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    vend_controller_if #(.VAL_W(16), .CNT_W(8)) bus ();

    vend_controller #(
        .VAL_W (16),
        .CNT_W (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        busy;
        logic        vend;
        logic [2:0]  addr;
        logic [3:0]  coin;
        logic        clr;
        logic [1:0]  err;
        logic [15:0] owed;
    } exp_t;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_cycle(input string tag, input exp_t e);
        chk({tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
        chk({tag, ".vend"}, 32'(bus.vend), 32'(e.vend));
        chk({tag, ".coin"}, 32'(bus.coin_out), 32'(e.coin));
        chk({tag, ".clr"}, 32'(bus.credit_clr), 32'(e.clr));
        chk({tag, ".err"}, 32'(bus.err), 32'(e.err));
        chk({tag, ".owed"}, 32'(bus.change_owed), 32'(e.owed));
        if (e.vend) chk({tag, ".addr"}, 32'(bus.vend_addr), 32'(e.addr));
    endtask

    // mode: 0 buy, 1 cancel, 2 buy and cancel together
    task automatic run_txn(input string tag, input int mode,
                           input int cr, input int pr, input int sl,
                           input int s0, input int s1,
                           input int s2, input int s3,
                           input bit noise, input int abort_at);
        exp_t q[$];
        exp_t e;
        int   den[4];
        int   cnt[4];
        int   coins[$];
        int   r;
        int   fin_err;
        bit   ok;
        den = '{500, 1000, 2000, 5000};
        cnt = '{s0, s1, s2, s3};
        ok  = (mode != 0) || (cr >= pr);
        r   = (mode != 0) ? cr : cr - pr;
        if (ok) begin
            forever begin
                int pk;
                pk = -1;
                for (int i = 3; i >= 0; i--)
                    if (pk < 0 && den[i] <= r && cnt[i] > 0) pk = i;
                if (r == 0 || pk < 0) break;
                coins.push_back(pk);
                r = r - den[pk];
                cnt[pk] = cnt[pk] - 1;
            end
        end
        fin_err = (r != 0) ? 2 : 0;

        e = '0;
        e.busy = 1'b1;
        if (!ok) begin
            q.push_back(e);
            e.err = 2'b01;
            q.push_back(e);
            e.busy = 1'b0;
            q.push_back(e);
        end else begin
            q.push_back(e);
            if (mode == 0) begin
                e.vend = 1'b1;
                e.addr = 3'(sl);
                q.push_back(e);
                e.vend = 1'b0;
                e.addr = '0;
                q.push_back(e);
            end
            foreach (coins[k]) begin
                e.coin = 4'(1 << coins[k]);
                q.push_back(e);
            end
            e.coin = '0;
            e.clr  = 1'b1;
            e.err  = 2'(fin_err);
            e.owed = 16'(r);
            q.push_back(e);
            e.clr  = 1'b0;
            e.busy = 1'b0;
            q.push_back(e);
        end

        bus.credit     = 16'(cr);
        bus.price      = 16'(pr);
        bus.sel        = 3'(sl);
        bus.stock_500  = 8'(s0);
        bus.stock_1000 = 8'(s1);
        bus.stock_2000 = 8'(s2);
        bus.stock_5000 = 8'(s3);
        bus.buy        = (mode != 1);
        bus.cancel     = (mode != 0);
        @(negedge clock);

        foreach (q[j]) begin
            check_cycle($sformatf("%s.c%0d", tag, j), q[j]);
            if (j == abort_at) begin
                reset      = 1'b0;
                bus.buy    = 1'b0;
                bus.cancel = 1'b0;
                @(negedge clock);
                check_cycle({tag, ".rst"}, '0);
                chk({tag, ".rst.addr"}, 32'(bus.vend_addr), 32'd0);
                reset = 1'b1;
                return;
            end
            if (noise && q[j].busy) begin
                bus.buy        = 1'($urandom_range(0, 1));
                bus.cancel     = 1'($urandom_range(0, 1));
                bus.credit     = 16'($urandom_range(0, 20000));
                bus.price      = 16'($urandom_range(0, 20000));
                bus.sel        = 3'($urandom_range(0, 7));
                bus.stock_500  = 8'($urandom_range(0, 9));
                bus.stock_1000 = 8'($urandom_range(0, 9));
                bus.stock_2000 = 8'($urandom_range(0, 9));
                bus.stock_5000 = 8'($urandom_range(0, 9));
            end else begin
                bus.buy    = 1'b0;
                bus.cancel = 1'b0;
            end
            if (j < q.size() - 1) @(negedge clock);
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.credit     = '0;
        bus.price      = '0;
        bus.sel        = '0;
        bus.buy        = 1'b0;
        bus.cancel     = 1'b0;
        bus.stock_500  = '0;
        bus.stock_1000 = '0;
        bus.stock_2000 = '0;
        bus.stock_5000 = '0;
        repeat (3) @(negedge clock);
        check_cycle("reset", '0);
        chk("reset.addr", 32'(bus.vend_addr), 32'd0);
        reset = 1'b1;

        run_txn("change3", 0, 5000, 1500, 2, 10, 10, 10, 10, 1'b1, -1);
        run_txn("nocredit", 0, 1000, 2500, 5, 10, 10, 10, 10, 1'b0, -1);
        run_txn("shortfall", 0, 3500, 500, 1, 1, 0, 1, 0, 1'b0, -1);
        run_txn("cancelwin", 2, 7000, 900, 3, 10, 10, 10, 10, 1'b0, -1);
        run_txn("abort", 0, 5000, 1500, 2, 10, 10, 10, 10, 1'b1, 4);
        run_txn("exact", 0, 2000, 2000, 6, 10, 10, 10, 10, 1'b1, -1);
        run_txn("cancel0", 1, 0, 0, 0, 5, 5, 5, 5, 1'b1, -1);
        run_txn("zerostk", 1, 1500, 0, 0, 0, 0, 0, 0, 1'b0, -1);

        for (int k = 0; k < 40; k++) begin
            run_txn($sformatf("rnd%0d", k),
                    int'($urandom_range(0, 2)),
                    500 * int'($urandom_range(0, 24)),
                    100 * int'($urandom_range(0, 60)),
                    int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)),
                    1'b1, -1);
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
